// File: rtl/rr_index_arb.sv
// rtl/rr_index_arb.sv - round-robin 8-way index arbiter with hold timeout
module rr_index_arb #(
   parameter int TMO = 15,
   parameter int CW  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic       en,
   output logic [2:0] i,
   output logic       tmo
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Counter value on the last cycle of a grant; releasing on the next edge keeps en high TMO cycles.
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

   state_t        state_q, state_d;
   logic          en_q, en_d;
   logic [2:0]    i_q, i_d;
   logic          tmo_q, tmo_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [2:0]    sel_idx;
   logic          sel_valid;

   // First requesting channel at or above ptr, wrapping 7->0; the downward loop lets the nearest offset win.
   always_comb begin
      sel_idx   = ptr_q;
      sel_valid = |req;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr_q + 3'(k)]) begin
            sel_idx = ptr_q + 3'(k);
         end
      end
   end

   // Next-state logic: grant from IDLE, hold until done or timeout, then release and advance ptr.
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      i_d     = i_q;
      tmo_d   = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d = GRANT;
               en_d    = 1'b1;
               i_d     = sel_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + 1'b1;
            if (done) begin
               state_d = IDLE;
               en_d    = 1'b0;
               ptr_d   = i_q + 3'd1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               en_d    = 1'b0;
               ptr_d   = i_q + 3'd1;
               tmo_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            en_d    = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything at once, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         i_q     <= 3'd0;
         tmo_q   <= 1'b0;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         i_q     <= i_d;
         tmo_q   <= tmo_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign en  = en_q;
   assign i   = i_q;
   assign tmo = tmo_q;

endmodule

// File: doc/rr_index_arb.md
RR_INDEX_ARB -- requirements
Module: rr_index_arb

Interface
REQ-001 Parameter TMO, default 15, is the maximum number of cycles a grant holds; legal range 1..2^CW-1.
REQ-002 Parameter CW, default 4, is the width of the hold counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  8  request lines; bit k requests channel k.
REQ-006 done  input  1  release pulse from the granted channel, sampled only while granted.
REQ-007 en  output  1  grant valid; drives the downstream 3-to-8 decoder enable.
REQ-008 i  output  3  granted channel index; drives the downstream decoder select.
REQ-009 tmo  output  1  one-cycle pulse when a grant is released by timeout.

Function
REQ-010 en, i and tmo SHALL be registered outputs, with no combinational path from inputs to outputs.
REQ-011 The FSM SHALL have exactly two states: IDLE (en=0) and GRANT (en=1).
REQ-012 In IDLE with req != 0, the block SHALL select the first set bit of req scanning upward from pointer ptr, wrapping 7->0.
REQ-013 On the edge that samples a valid IDLE selection, the block SHALL load i with the selected index, set en=1, clear the hold counter and enter GRANT (latency: 1 cycle from req sampled to en high).
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE with en=0 and i holding its last value.
REQ-015 In GRANT, i SHALL stay stable, and the hold counter SHALL increment by one each cycle.
REQ-016 In GRANT, the block SHALL ignore req changes, including the granted bit dropping, with no preemption.
REQ-017 In GRANT with done=1, the next edge SHALL set en=0, load ptr=i+1 mod 8 and return to IDLE.
REQ-018 In GRANT with done=0 and counter == TMO-1, the next edge SHALL release as in REQ-017 and assert tmo=1 for exactly one cycle, so en stays high exactly TMO cycles.
REQ-019 When done=1 coincides with counter == TMO-1, the release SHALL count as done, with tmo staying 0.
REQ-020 After any release, en SHALL be low for at least one cycle before the next grant.
REQ-021 done SHALL be ignored in IDLE.
REQ-022 ptr SHALL wrap modulo 8 (i=7 released gives ptr=0), and counter arithmetic SHALL be unsigned CW-bit.

Reset
REQ-023 rst_n=0 SHALL immediately force en=0, i=0, tmo=0, ptr=0, counter=0 and state IDLE, regardless of clk.
REQ-024 Reset asserted mid-GRANT SHALL abort the grant without a tmo pulse; after rst_n rises, arbitration SHALL resume from ptr=0.
REQ-025 Reset deassertion SHALL be synchronised externally; the block SHALL require no warm-up cycles.

Verification
REQ-026 The bench SHALL cover: reset, req=8'b0000_0100 -> after 1 edge en=1, i=3'd2; done pulse -> next edge en=0, tmo=0.
REQ-027 The bench SHALL cover rotation: req=8'hFF held with done pulsed every grant -> i sequence 0,1,2,...,7,0, each separated by one en=0 cycle.
REQ-028 The bench SHALL cover timeout: TMO=15, req=8'h01, done never asserted -> en high exactly 15 cycles, then tmo=1 for 1 cycle, then en=0.
REQ-029 The bench SHALL cover the simultaneous case: done=1 on the 15th grant cycle -> release with tmo=0.
REQ-030 The bench SHALL cover wrap and skip: grant i=6 released, req=8'b0100_0001 -> next grant i=0 (ptr=7 scans 7, then 0).
REQ-031 The bench SHALL cover asynchronous reset: rst_n pulled low mid-GRANT between clock edges -> en=0 and i=0 immediately; after release, req=8'h80 -> i=7 after 1 edge.
